// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
// Holds the 2-bit saturating counter encoding and its init/allocate values.
package btb_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_INIT  = WNT;
  localparam ctr_t CTR_ALLOC = WT;

endpackage

// File: rtl/btb_predictor_sat_counter2.sv
// 2-bit saturating counter next-state, purely combinational.
// Taken counts up toward ST, not-taken counts down toward SNT; both saturate.
module sat_counter2
  import btb_predictor_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken && (cur != ST)) begin
      nxt = ctr_t'(cur + 2'd1);
    end else if (!taken && (cur != SNT)) begin
      nxt = ctr_t'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup on pc_if, one EX update per cycle.
// Updates land on the clock edge and are visible to lookup the next cycle; no same-cycle bypass.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  input  logic        update_btb_ex,
  input  logic [31:0] pc_ex,
  input  logic        ex_branch_taken,
  input  logic [31:0] jump_addr_ex,
  input  logic        modify_pc_ex,
  input  logic [31:0] update_pc_ex,
  output logic        btb_hit_if,
  output logic        predicted_taken_if,
  output logic [31:0] predicted_target_if,
  output logic [31:0] next_pc_if
);

  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [ENTRIES];
  ctr_t             ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];

  logic [IDX_W-1:0] idx_if;
  logic [IDX_W-1:0] idx_ex;
  logic [TAG_W-1:0] tag_if;
  logic [TAG_W-1:0] tag_ex;
  logic             upd_hit;
  ctr_t             ctr_nxt;

  // Byte offset within the word never participates in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_if[1:0], pc_ex[1:0]};

  assign idx_if = pc_if[IDX_W+1:2];
  assign tag_if = pc_if[31:IDX_W+2];
  assign idx_ex = pc_ex[IDX_W+1:2];
  assign tag_ex = pc_ex[31:IDX_W+2];

  assign upd_hit = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  sat_counter2 u_sat_counter2 (
    .cur   (ctr_q[idx_ex]),
    .taken (ex_branch_taken),
    .nxt   (ctr_nxt)
  );

  always_comb begin
    btb_hit_if          = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    predicted_taken_if  = btb_hit_if && ctr_q[idx_if][1];
    predicted_target_if = btb_hit_if ? tgt_q[idx_if] : 32'h0;
    if (modify_pc_ex) begin
      next_pc_if = update_pc_ex;
    end else if (predicted_taken_if) begin
      next_pc_if = predicted_target_if;
    end else begin
      next_pc_if = pc_if + 32'd4;
    end
  end

  // Control state: valid bits and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (update_btb_ex) begin
      if (upd_hit) begin
        ctr_q[idx_ex] <= ctr_nxt;
      end else if (ex_branch_taken) begin
        valid_q[idx_ex] <= 1'b1;
        ctr_q[idx_ex]   <= CTR_ALLOC;
      end
    end
  end

  // Tag/target payload needs no reset; the valid bit guards it.
  // A taken update either refreshes the target on a hit or allocates on a miss.
  always_ff @(posedge clk) begin
    if (rst_n && update_btb_ex && ex_branch_taken) begin
      tag_q[idx_ex] <= tag_ex;
      tgt_q[idx_ex] <= jump_addr_ex;
    end
  end

endmodule
